// File: rtl/riscv_defines_pkg.sv
// rtl/riscv_defines_pkg.sv - shared widths, limits and arbiter state type
package riscv_defines;

  localparam int ARB_DATA_WIDTH   = 32;
  localparam int ARB_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto one shared memory port
module mem_arbiter
  import riscv_defines::*;
#(
  parameter int DATA_WIDTH   = ARB_DATA_WIDTH,
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [DATA_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ready,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  arb_state_t            r_state;
  arb_state_t            w_next_state;
  logic [CW-1:0]         r_starve;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  w_starved;
  logic                  w_grant_d;
  logic                  w_grant_i;

  assign w_starved = (r_starve == CW'(STARVE_LIMIT));

  always_comb begin
    w_next_state = r_state;
    w_grant_d    = 1'b0;
    w_grant_i    = 1'b0;
    case (r_state)
      IDLE: begin
        // data normally wins; a starved, still-waiting fetch takes one turn
        if (d_req && !(w_starved && if_req)) begin
          w_grant_d    = 1'b1;
          w_next_state = BUSY_D;
        end else if (if_req) begin
          w_grant_i    = 1'b1;
          w_next_state = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_starve <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_grant_d) begin
        r_addr  <= d_addr;
        r_we    <= d_we;
        r_wdata <= d_wdata;
        if (if_req && !w_starved) r_starve <= r_starve + 1'b1;
      end else if (w_grant_i) begin
        r_addr   <= if_addr;
        r_we     <= 1'b0;
        r_wdata  <= '0;
        r_starve <= '0;
      end
    end
  end

  assign mem_req   = (r_state != IDLE);
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  assign if_ready  = (r_state == BUSY_I) && mem_ready;
  assign d_ready   = (r_state == BUSY_D) && mem_ready;
  assign if_rdata  = if_ready ? mem_rdata : '0;
  assign d_rdata   = d_ready  ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;
  import riscv_defines::*;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we, mem_ready;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ready, d_ready, mem_req, mem_we;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.DATA_WIDTH(32), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic do_reset();
    rst_n = 1'b0; if_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0; if_req = 1; d_req = 1; d_we = 1; mem_ready = 1;
    d_addr = 32'h55; d_wdata = 32'h66; mem_rdata = 32'h77;
    @(negedge clk);
    n_checks++; if ({mem_req, mem_we, if_ready, d_ready} !== 4'b0) begin n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0000", {mem_req, mem_we, if_ready, d_ready}); end
    n_checks++; if (mem_addr !== 32'h0) begin n_fail++;
      $display("FAIL reset_addr: got %h expected 0", mem_addr); end
    n_checks++; if (mem_wdata !== 32'h0) begin n_fail++;
      $display("FAIL reset_wdata: got %h expected 0", mem_wdata); end
    n_checks++; if ({if_rdata, d_rdata} !== 64'h0) begin n_fail++;
      $display("FAIL reset_rdata: got %h expected 0", {if_rdata, d_rdata}); end
    @(posedge clk); #1;
    do_reset();
  endtask

  task automatic test_fetch();
    do_reset();
    if_req = 1; if_addr = 32'h10; mem_ready = 0;
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b0) begin n_fail++;
      $display("FAIL fetch_cycleN_req: got %b expected 0", mem_req); end
    @(posedge clk); #1; mem_ready = 1; mem_rdata = 32'h00500093;
    @(negedge clk);
    n_checks++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h10}) begin n_fail++;
      $display("FAIL fetch_bus: got %b %b %h expected 1 0 00000010", mem_req, mem_we, mem_addr); end
    n_checks++; if ({if_ready, d_ready, if_rdata} !== {2'b10, 32'h00500093}) begin n_fail++;
      $display("FAIL fetch_ready: got %b %b %h expected 1 0 00500093", if_ready, d_ready, if_rdata); end
    @(posedge clk); #1; if_req = 0; mem_ready = 0;
    @(negedge clk);
    n_checks++; if ({mem_req, if_ready, if_rdata} !== 34'h0) begin n_fail++;
      $display("FAIL fetch_after: got %b %b %h expected 0 0 0", mem_req, if_ready, if_rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_both();
    do_reset();
    if_req = 1; if_addr = 32'h20; d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    @(posedge clk); #1; mem_ready = 1; mem_rdata = 32'h1;
    @(negedge clk);
    n_checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h100, 32'hDEADBEEF}) begin n_fail++;
      $display("FAIL both_first_bus: got %b %b %h %h expected 1 1 00000100 deadbeef", mem_req, mem_we, mem_addr, mem_wdata); end
    n_checks++; if ({d_ready, if_ready} !== 2'b10) begin n_fail++;
      $display("FAIL both_first_ready: got d=%b i=%b expected d=1 i=0", d_ready, if_ready); end
    @(posedge clk); #1; d_req = 0; mem_ready = 0;
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b0) begin n_fail++;
      $display("FAIL both_bubble: got %b expected 0", mem_req); end
    @(posedge clk); #1; mem_ready = 1; mem_rdata = 32'hABCD0123;
    @(negedge clk);
    n_checks++; if ({mem_req, mem_we, mem_addr, if_ready, if_rdata} !== {2'b10, 32'h20, 1'b1, 32'hABCD0123}) begin n_fail++;
      $display("FAIL both_second: got %b %b %h %b %h expected 1 0 00000020 1 abcd0123", mem_req, mem_we, mem_addr, if_ready, if_rdata); end
    @(posedge clk); #1; if_req = 0; mem_ready = 0;
  endtask

  task automatic test_starve();
    int got = 0;
    logic exp_i;
    do_reset();
    if_req = 1; if_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h300; mem_ready = 1;
    for (int c = 0; c < 60 && got < 10; c++) begin
      mem_rdata = $urandom;
      @(negedge clk);
      if (mem_req) begin
        exp_i = ((got % (LIM + 1)) == LIM);
        n_checks++; if ({if_ready, d_ready} !== {exp_i, ~exp_i}) begin n_fail++;
          $display("FAIL starve_order[%0d]: got i=%b d=%b expected i=%b d=%b", got, if_ready, d_ready, exp_i, ~exp_i); end
        got++;
      end
      @(posedge clk); #1;
    end
    n_checks++; if (got != 10) begin n_fail++;
      $display("FAIL starve_timeout: got %0d grants expected 10", got); end
    if_req = 0; d_req = 0; mem_ready = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    do_reset();
    d_req = 1; d_we = 0; d_addr = 32'h200; mem_ready = 0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      mem_ready = (k == 3);
      mem_rdata = (k == 3) ? 32'h12345678 : $urandom;
      @(negedge clk);
      n_checks++; if ({mem_req, mem_addr, d_ready} !== {1'b1, 32'h200, (k == 3)}) begin n_fail++;
        $display("FAIL latency_cyc%0d: got %b %h %b expected 1 00000200 %b", k, mem_req, mem_addr, d_ready, (k == 3)); end
      n_checks++; if (d_rdata !== ((k == 3) ? 32'h12345678 : 32'h0)) begin n_fail++;
        $display("FAIL latency_rdata%0d: got %h expected %h", k, d_rdata, (k == 3) ? 32'h12345678 : 32'h0); end
    end
    @(posedge clk); #1; d_req = 0; mem_ready = 0;
    @(negedge clk);
    n_checks++; if ({mem_req, d_ready} !== 2'b00) begin n_fail++;
      $display("FAIL latency_after: got %b %b expected 0 0", mem_req, d_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    if_req = 1; if_addr = 32'h80; d_req = 1; d_we = 1; d_addr = 32'h400; d_wdata = $urandom; mem_ready = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h400}) begin n_fail++;
      $display("FAIL rstmid_busy: got %b %h expected 1 00000400", mem_req, mem_addr); end
    mem_ready = 1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({mem_req, mem_we, d_ready, if_ready} !== 4'b0) begin n_fail++;
      $display("FAIL rstmid_ctrl: got %b expected 0000", {mem_req, mem_we, d_ready, if_ready}); end
    n_checks++; if ({mem_addr, mem_wdata, d_rdata} !== 96'h0) begin n_fail++;
      $display("FAIL rstmid_data: got %h expected 0", {mem_addr, mem_wdata, d_rdata}); end
    n_checks++; if (dut.r_state !== IDLE || dut.r_starve !== '0) begin n_fail++;
      $display("FAIL rstmid_state: got state=%0d cnt=%0d expected 0 0", dut.r_state, dut.r_starve); end
    d_req = 0; mem_ready = 0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b0) begin n_fail++;
      $display("FAIL rstmid_release: got %b expected 0", mem_req); end
    @(posedge clk); #1; mem_ready = 1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    n_checks++; if ({mem_req, mem_addr, if_ready, if_rdata} !== {1'b1, 32'h80, 1'b1, 32'hCAFEF00D}) begin n_fail++;
      $display("FAIL rstmid_fetch: got %b %h %b %h expected 1 00000080 1 cafef00d", mem_req, mem_addr, if_ready, if_rdata); end
    @(posedge clk); #1; if_req = 0; mem_ready = 0;
  endtask

  // Reference: who owns memory (0 none, 1 fetch, 2 data), remaining wait, starvation tally.
  task automatic test_random(input int n);
    int          owner = 0, cnt = 0, wait_c = 0;
    logic        f_act = 0, d_act = 0, m_we = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, e_i, e_d;
    do_reset();
    for (int c = 0; c < n; c++) begin
      if (!f_act) begin
        if_req = 0;
        if ($urandom_range(0, 2) != 0) begin f_act = 1; if_req = 1; if_addr = $urandom; end
      end else if (owner == 1 && $urandom_range(0, 5) == 0) if_req = 0;
      if (!d_act) begin
        d_req = 0;
        if ($urandom_range(0, 2) != 0) begin
          d_act = 1; d_req = 1; d_we = $urandom_range(0, 1); d_addr = $urandom; d_wdata = $urandom;
        end
      end else if (owner == 2 && $urandom_range(0, 5) == 0) d_req = 0;
      mem_ready = (owner != 0) ? (wait_c == 0) : 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      @(negedge clk);
      e_i = (owner == 1 && mem_ready) ? mem_rdata : 32'h0;
      e_d = (owner == 2 && mem_ready) ? mem_rdata : 32'h0;
      n_checks++; if (mem_req !== (owner != 0)) begin n_fail++;
        $display("FAIL rand_req@%0d: got %b expected %b", c, mem_req, owner != 0); end
      if (owner != 0) begin
        n_checks++; if ({mem_we, mem_addr} !== {m_we, m_addr} || (m_we && mem_wdata !== m_wdata)) begin n_fail++;
          $display("FAIL rand_bus@%0d: got %b %h %h expected %b %h %h", c, mem_we, mem_addr, mem_wdata, m_we, m_addr, m_wdata); end
      end
      n_checks++; if ({if_ready, d_ready} !== {(owner == 1) && mem_ready, (owner == 2) && mem_ready}) begin n_fail++;
        $display("FAIL rand_ready@%0d: got i=%b d=%b owner=%0d mem_ready=%b", c, if_ready, d_ready, owner, mem_ready); end
      n_checks++; if ({if_rdata, d_rdata} !== {e_i, e_d}) begin n_fail++;
        $display("FAIL rand_rdata@%0d: got %h %h expected %h %h", c, if_rdata, d_rdata, e_i, e_d); end
      if (owner != 0) begin
        if (mem_ready) begin
          if (owner == 1) f_act = 0; else d_act = 0;
          owner = 0;
        end else wait_c--;
      end else if (d_req && !(cnt == LIM && if_req)) begin
        owner = 2; m_addr = d_addr; m_we = d_we; m_wdata = d_wdata;
        if (if_req && cnt < LIM) cnt++;
        wait_c = $urandom_range(0, 3);
      end else if (if_req) begin
        owner = 1; m_addr = if_addr; m_we = 0; cnt = 0;
        wait_c = $urandom_range(0, 3);
      end
      @(posedge clk); #1;
    end
    if_req = 0; d_req = 0; mem_ready = 0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_both();
    test_starve();
    test_latency();
    test_reset_mid();
    test_random(800);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
